// File: rtl/dmem_arb.sv
// Two-port arbiter in front of a single-port data memory with 1-cycle read latency.
// Port 0 (CPU) has priority; port 1 (loader/debug) is forced through after STARVE_LIM contested losses.
module dmem_arb #(
    parameter int          STARVE_LIM = 4,
    parameter logic [8:0]  DMEM_TAG   = 9'b000000001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_d,
    input  logic [3:0]  m0_we,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_q,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_d,
    input  logic [3:0]  m1_we,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_q,
    output logic        m1_err,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_d,
    output logic [3:0]  mem_we,
    input  logic [31:0] mem_q
);
    // Handshake: a request is accepted (and the transfer complete) in any cycle where
    // mX_req && mX_gnt; nothing is queued. The response (mX_rvalid) follows exactly
    // one cycle after acceptance, for reads and writes alike.

    localparam int         CW  = $clog2(STARVE_LIM + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

    logic [CW-1:0] starve_cnt;
    logic          contested;
    logic          any_gnt;
    logic          in_range;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_d;
    logic [3:0]    sel_we;

    logic          rsp_valid;
    logic          rsp_port;
    logic          rsp_err;

    assign contested = m0_req && m1_req;
    assign m1_gnt    = !rst && m1_req && (!m0_req || (starve_cnt == LIM));
    assign m0_gnt    = !rst && m0_req && !m1_gnt;
    assign any_gnt   = m0_gnt || m1_gnt;

    always_comb begin
        sel_addr = '0;
        sel_d    = '0;
        sel_we   = '0;
        if (m1_gnt) begin
            sel_addr = m1_addr;
            sel_d    = m1_d;
            sel_we   = m1_we;
        end else if (m0_gnt) begin
            sel_addr = m0_addr;
            sel_d    = m0_d;
            sel_we   = m0_we;
        end
    end

    assign in_range = (sel_addr[31:23] == DMEM_TAG);
    assign mem_en   = any_gnt && in_range;
    assign mem_addr = sel_addr;
    assign mem_d    = sel_d;
    assign mem_we   = mem_en ? sel_we : 4'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (m1_gnt) begin
            starve_cnt <= '0;
        end else if (contested && m0_gnt && (starve_cnt != LIM)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Response routing is captured at grant time so requests in the response cycle cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_port  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= any_gnt;
            rsp_port  <= m1_gnt;
            rsp_err   <= any_gnt && !in_range;
        end
    end

    // Gating with rst drops a response whose grant happened just before reset asserted.
    assign m0_rvalid = !rst && rsp_valid && !rsp_port;
    assign m1_rvalid = !rst && rsp_valid &&  rsp_port;
    assign m0_err    = m0_rvalid && rsp_err;
    assign m1_err    = m1_rvalid && rsp_err;
    assign m0_q      = (m0_rvalid && !rsp_err) ? mem_q : 32'h0;
    assign m1_q      = (m1_rvalid && !rsp_err) ? mem_q : 32'h0;

endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 SHALL have parameter: STARVE_LIM, default 4, number of consecutive contested cycles port 0 may win before port 1 is forced.
REQ-002 SHALL have parameter: DMEM_TAG, default 9'b000000001, required value of addr[31:23] for an address to be a dmem address.
REQ-003 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: m0_req  in  1, m0_addr  in  32, m0_d  in  32, m0_we  in  4  as the port-0 (CPU) request, word address, write data and byte enables.
REQ-006 SHALL have ports: m0_gnt  out  1, m0_rvalid  out  1, m0_q  out  32, m0_err  out  1  as the port-0 grant, response valid, read data and address error.
REQ-007 SHALL have ports: m1_req, m1_addr, m1_d, m1_we, m1_gnt, m1_rvalid, m1_q, m1_err, with the same directions and widths as port 0, as the port-1 (loader/debug) interface.
REQ-008 SHALL have ports: mem_en  out  1, mem_addr  out  32, mem_d  out  32, mem_we  out  4, mem_q  in  32  as the interface to the single-port dmem, which has 1-cycle read latency.

Function
REQ-009 SHALL compute grant combinationally: at most one of m0_gnt/m1_gnt high per cycle; mX_gnt=0 whenever mX_req=0.
REQ-010 SHALL follow this grant rule:
- only one port requesting: that port is granted.
- both requesting: port 0 is granted unless the starvation counter equals STARVE_LIM, in which case port 1 is granted.
REQ-011 SHALL define the starvation counter (width clog2(STARVE_LIM+1)) update on each clock as follows:
- contested cycle where port 0 is granted: increment, saturating at STARVE_LIM.
- port 1 granted: clear to 0.
- any non-contested cycle: hold.
REQ-012 SHALL drive mem_addr/mem_d/mem_we combinationally from the granted port, and drive them to 0 when there is no grant.
REQ-013 SHALL assert mem_en only when there is a grant and the granted port's addr[31:23]==DMEM_TAG; on an out-of-range grant mem_en=0 and mem_we=0.
REQ-014 SHALL treat a grant as a completed transfer: the requester may change its request in the next cycle; requests are not queued.
REQ-015 SHALL produce a response exactly one cycle after a grant:
- the granted port's mX_rvalid=1, for reads and writes alike.
- the other port's rvalid=0.
- rvalid is a one-cycle pulse per grant.
REQ-016 SHALL route read data as mX_q=mem_q when mX_rvalid=1 and the transfer was in range; otherwise mX_q=0.
REQ-017 SHALL assert mX_err together with mX_rvalid when the granted address was out of range; mX_q=0 in that case.
REQ-018 SHALL record the response routing (port select, valid, error) in registers at grant time; it is unaffected by requests in the response cycle.
REQ-019 SHALL support back-to-back grants: a new grant in cycle N+1 coexists with the response for the grant in cycle N (full throughput, one transfer per cycle).
REQ-020 SHALL pass write-enable bytes unmodified; byte merging is performed by dmem.

Reset
REQ-021 SHALL, while rst=1 at a clock edge, clear: starvation counter, response-valid register, response port select, and error register.
REQ-022 SHALL force m0_gnt, m1_gnt and mem_en to 0 while rst=1, regardless of requests.
REQ-023 SHALL, in the cycle after reset deasserts, drive m0_rvalid, m1_rvalid, m0_err, m1_err, m0_q and m1_q as 0.
REQ-024 SHALL drop a response pending from a grant in the cycle before rst asserts: no rvalid is issued for it.

Verification
REQ-025 SHALL be verified by single-port read: m0_req=1, addr=0x00800010 on cycle N -> m0_gnt=1 and mem_en=1 in cycle N; m0_rvalid=1 with m0_q=mem_q in cycle N+1; m0_err=0.
REQ-026 SHALL be verified by contention with STARVE_LIM=4: both ports requesting continuously -> grant sequence 0,0,0,0,1,0,0,0,0,1,... with m1 granted every 5th cycle.
REQ-027 SHALL be verified by an out-of-range write: m1_req=1, addr=0x00000040, we=4'hF -> m1_gnt=1 with mem_en=0 and mem_we=0; next cycle m1_rvalid=1, m1_err=1, m1_q=0.
REQ-028 SHALL be verified by back-to-back alternation: port 0 read at cycle N, port 1 read at cycle N+1 -> m0_rvalid at N+1 and m1_rvalid at N+2, each carrying the mem_q of its own access and never the other port's data.
REQ-029 SHALL be verified by reset mid-stream: grant at cycle N, rst=1 during cycle N+1 -> no rvalid at N+1; counter=0 and all gnt=0 during reset.
REQ-030 SHALL be verified by counter hold: after 3 contested port-0 wins, 2 idle cycles, then contention again -> exactly 1 more port-0 win before port 1 is granted.
